dm_wait_responder: RTL and testbench
====================================

// Module: dm_wait_responder
// PURPOSE
//  Multi-cycle data-memory responder on the MEM-stage side of the pipelined CPU.
//  Accepts one load or store per request (memRead/memWrite, byte address, write data).
//  Asserts stall while the access is in progress, so PC, IF/ID, ID/EX, EX/MEM and MEM/WB hold.
//  Completes the access after a fixed number of wait states and returns load data with a one-cycle ready pulse.
// PARAMETERS
//  WORDS    1024  depth of the word array; legal byte addresses are 0 .. WORDS*4-1
//  LATENCY  2     BUSY wait states, legal range >= 1; total stall cycles per legal access = LATENCY+1
//  AW       10    word-index width; must equal clog2(WORDS)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   asynchronous, active-low reset
//  memRead    in   1   load request from EX/MEM
//  memWrite   in   1   store request from EX/MEM
//  inAddr     in   32  byte address (ALU result)
//  writeData  in   32  store data
//  outData    out  32  load data; holds the last completed load value
//  stall      out  1   high = hold the pipeline this cycle
//  ready      out  1   one-cycle pulse: access finished, outData valid for a load
//  err        out  1   one-cycle pulse together with ready: request was illegal, no access made
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, outData=0, stall=0, ready=0, err=0, counter=0. Array contents are NOT reset.
//  Request: req = memRead | memWrite, sampled only in IDLE.
//  Legal request: exactly one of memRead/memWrite is high, inAddr[1:0]==0, and inAddr < WORDS*4.
//  FSM states IDLE, BUSY, DONE:
//   IDLE: stall = req (combinational, same cycle).
//     On an edge with req: latch op, word index inAddr[AW+1:2], writeData and the legal flag.
//     Legal request: go to BUSY with cnt=LATENCY-1. Illegal request: go to DONE.
//   BUSY: stall=1. While cnt!=0, each edge decrements cnt.
//     On the edge where cnt==0: perform the access (store writes the array; load registers array data into outData), then go to DONE.
//   DONE: stall=0, ready=1, err=illegal flag. On the next edge go to IDLE unconditionally.
//     Inputs seen in DONE belong to the completing instruction and are ignored.
//  Latency: a legal request seen in cycle 0 gives stall in cycles 0..LATENCY and ready in cycle LATENCY+1.
//   An illegal request gives stall in cycle 0 only, and ready+err in cycle 1.
//  Back-to-back: a request arriving in the cycle right after DONE is a new request and is accepted with no bubble.
//  Latched values are used for the access; input changes during BUSY have no effect.
//  Illegal request: no array write; outData unchanged. Illegal cases are both ops high, misaligned address, or out-of-range address.
//  Reset mid-access (BUSY): the pending store is dropped (array word keeps its old value); outData=0; all outputs take reset values.
//  outData changes only on a completed legal load or on reset.
// STRUCTURE
//  Shared package dm_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), DM_WORD_W=32, DM_BYTE_OFS=2.
//  One sub-module dm_ram_array: WORDS x 32, synchronous write and synchronous read.
//   Its ports are we, re, waddr/raddr[AW-1:0], wdata, rdata; no reset on the array.
//  Top level holds the FSM, cnt ($clog2(LATENCY)+1 bits), request latches, legality check, and output regs.
// TESTING
//  1 Store 0xDEADBEEF at 0x10, then load 0x10 (LATENCY=2) -> stall in 3 cycles each; load ready in cycle 3 with outData=0xDEADBEEF.
//  2 Load, store, load on consecutive requests (0x0, 0x4 <- 0x12345678, 0x4) -> no lost or duplicate access; final outData=0x12345678.
//  3 Misaligned load at 0x6 -> stall 1 cycle; ready=err=1 in cycle 1; outData unchanged; array unchanged.
//  4 memRead=memWrite=1 at 0x8, and a store at WORDS*4 -> err pulse each time; no array write (read-back of 0x8 shows old data).
//  5 rst=0 in the second BUSY cycle of a store 0xA5A5A5A5 to 0x20 -> outputs reset immediately; after release, a load of 0x20 returns the pre-store value.
//  6 Sweep LATENCY=1 and LATENCY=4 -> stall length = LATENCY+1 and exactly one ready pulse per legal request.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_e;

  localparam int DM_WORD_W   = 32;
  localparam int DM_BYTE_OFS = 2;

endpackage

// File: rtl/dm_ram_array.sv
// Word-wide data array: synchronous write and synchronous read, contents not reset.
module dm_ram_array
  import dm_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        waddr,
  input  logic [AW-1:0]        raddr,
  input  logic [DM_WORD_W-1:0] wdata,
  output logic [DM_WORD_W-1:0] rdata
);

  logic [DM_WORD_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dm_wait_responder.sv
// MEM-stage data-memory responder: stalls the pipeline for LATENCY+1 cycles per access,
// then pulses ready (and err for an illegal request) for one cycle.
//
//   state | meaning
//   IDLE  | waiting; stall follows the incoming request combinationally
//   BUSY  | wait states counting down; access performed on the cnt==0 edge
//   DONE  | one-cycle completion: ready=1, err=illegal flag
module dm_wait_responder
  import dm_pkg::*;
#(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2,
  parameter int AW      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic [DM_WORD_W-1:0] inAddr,
  input  logic [DM_WORD_W-1:0] writeData,
  output logic [DM_WORD_W-1:0] outData,
  output logic                 stall,
  output logic                 ready,
  output logic                 err
);

  localparam int              CW         = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0]   CNT_INIT   = CW'(LATENCY - 1);
  localparam logic [32:0]     ADDR_LIMIT = 33'(WORDS) * 33'd4;

  dm_state_e state, state_nxt;

  logic [CW-1:0]        cnt;
  logic                 ld_q;
  logic                 legal_q;
  logic [AW-1:0]        widx_q;
  logic [DM_WORD_W-1:0] wdata_q;

  logic                 req;
  logic                 legal_in;
  logic                 last_busy;
  logic                 ram_we;
  logic                 ram_re;
  logic [AW-1:0]        widx_in;
  logic [DM_WORD_W-1:0] rdata;

  assign req       = memRead | memWrite;
  assign widx_in   = inAddr[AW+DM_BYTE_OFS-1:DM_BYTE_OFS];
  assign legal_in  = (memRead ^ memWrite)
                   && (inAddr[DM_BYTE_OFS-1:0] == '0)
                   && ({1'b0, inAddr} < ADDR_LIMIT);
  assign last_busy = (state == BUSY) && (cnt == '0);

  // Loads read the array on the accept edge so the word is already waiting
  // in rdata when the final wait state completes, even for LATENCY=1.
  assign ram_re = (state == IDLE) && memRead && legal_in;
  assign ram_we = last_busy && !ld_q;

  dm_ram_array #(
    .WORDS(WORDS),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .waddr(widx_q),
    .raddr(widx_in),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ld_q    <= 1'b0;
      legal_q <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      outData <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && req) begin
        ld_q    <= memRead;
        legal_q <= legal_in;
        widx_q  <= widx_in;
        wdata_q <= writeData;
        cnt     <= CNT_INIT;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (last_busy && ld_q) outData <= rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ready     = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = legal_in ? BUSY : DONE;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        err       = !legal_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_wait_responder.sv
// Bench for dm_wait_responder: timeline model checked every cycle plus directed literal checks.
module tb_dm_wait_responder;

  localparam int WORDS = 1024;
  localparam int L     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wd = '0;
  logic [31:0] out;
  logic        stall, ready, err;

  logic        a_rd = 1'b0, a_wr = 1'b0;
  logic [31:0] a_addr = '0, a_wd = '0;
  logic [31:0] out1, out4;
  logic        stall1, stall4, ready1, ready4, err1, err4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_wait_responder #(.WORDS(WORDS), .LATENCY(L), .AW(10)) dut (
    .clk(clk), .rst(rst), .memRead(rd), .memWrite(wr), .inAddr(addr), .writeData(wd),
    .outData(out), .stall(stall), .ready(ready), .err(err)
  );

  dm_wait_responder #(.WORDS(WORDS), .LATENCY(1), .AW(10)) dut1 (
    .clk(clk), .rst(rst), .memRead(a_rd), .memWrite(a_wr), .inAddr(a_addr), .writeData(a_wd),
    .outData(out1), .stall(stall1), .ready(ready1), .err(err1)
  );

  dm_wait_responder #(.WORDS(WORDS), .LATENCY(4), .AW(10)) dut4 (
    .clk(clk), .rst(rst), .memRead(a_rd), .memWrite(a_wr), .inAddr(a_addr), .writeData(a_wd),
    .outData(out4), .stall(stall4), .ready(ready4), .err(err4)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Timeline model: a request accepted in cycle t stalls through t+L and completes in t+L+1
  // (illegal: stall in t, ready+err in t+1); effects become visible in the completion cycle.
  logic [31:0] mem_m [int];
  logic [31:0] exp_out   = '0;
  bit          out_known = 1'b1;
  bit          m_busy    = 1'b0;
  bit          m_legal   = 1'b0;
  bit          m_load    = 1'b0;
  int          m_end     = 0;
  int          m_idx     = 0;
  logic [31:0] m_wd      = '0;
  int          cyc       = 0;

  always @(negedge clk) begin
    bit e_stall, e_ready, e_err;
    cyc++;
    e_stall = 1'b0;
    e_ready = 1'b0;
    e_err   = 1'b0;
    if (!rst) begin
      m_busy    = 1'b0;
      exp_out   = '0;
      out_known = 1'b1;
    end else if (!m_busy) begin
      if (rd || wr) begin
        m_legal = (rd != wr) && (addr[1:0] == 2'b00) && (addr < 32'(WORDS * 4));
        m_load  = rd;
        m_idx   = int'(addr >> 2);
        m_wd    = wd;
        m_busy  = 1'b1;
        m_end   = cyc + (m_legal ? L + 1 : 1);
        e_stall = 1'b1;
      end
    end else if (cyc < m_end) begin
      e_stall = 1'b1;
    end else begin
      e_ready = 1'b1;
      e_err   = !m_legal;
      m_busy  = 1'b0;
      if (m_legal && m_load) begin
        if (mem_m.exists(m_idx)) begin
          exp_out   = mem_m[m_idx];
          out_known = 1'b1;
        end else begin
          out_known = 1'b0;
        end
      end else if (m_legal) begin
        mem_m[m_idx] = m_wd;
      end
    end
    check("stall", {31'b0, stall}, {31'b0, e_stall});
    check("ready", {31'b0, ready}, {31'b0, e_ready});
    check("err",   {31'b0, err},   {31'b0, e_err});
    if (out_known) check("outData", out, exp_out);
  end

  // Issue one request at posedge+1 and follow it to its ready pulse; the inputs are
  // scrambled during the wait states to show the latched copies are used.
  task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int n_stall, output logic e, output logic [31:0] q);
    bit done;
    rd = r; wr = w; addr = a; wd = d;
    n_stall = 0; e = 1'b0; q = '0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (ready) begin
        e = err; q = out; done = 1'b1;
      end else begin
        @(posedge clk); #1;
        addr = a ^ 32'h0000_0ff0;
        wd   = ~d;
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL xact_timeout: got no ready expected ready within 20 cycles at %0t", $time);
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; addr = '0; wd = '0;
  endtask

  task automatic aux_xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int s1, output int s4, output int r1, output int r4, output int ec);
    a_rd = r; a_wr = w; a_addr = a; a_wd = d;
    s1 = 0; s4 = 0; r1 = 0; r4 = 0; ec = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      s1 += int'(stall1); s4 += int'(stall4);
      r1 += int'(ready1); r4 += int'(ready4);
      ec += int'(err1 | err4);
      if (k == 0) begin
        @(posedge clk); #1;
        a_rd = 1'b0; a_wr = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000 at %0t", $time);
    $fatal(1);
  end

  initial begin
    int          s, s1, s4, r1, r4, ec;
    logic        e;
    logic [31:0] q;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    rst = 1'b1;

    xact(1'b0, 1'b1, 32'h0, 32'hCAFE_0000, s, e, q);

    // Store then load one word
    xact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, s, e, q);
    check("t1_store_stall", s, 3);
    check("t1_store_err", {31'b0, e}, 32'h0);
    xact(1'b1, 1'b0, 32'h10, 32'h0, s, e, q);
    check("t1_load_stall", s, 3);
    check("t1_load_data", q, 32'hDEAD_BEEF);

    // Back-to-back load / store / load
    xact(1'b1, 1'b0, 32'h0, 32'h0, s, e, q);
    check("t2_load0", q, 32'hCAFE_0000);
    xact(1'b0, 1'b1, 32'h4, 32'h1234_5678, s, e, q);
    xact(1'b1, 1'b0, 32'h4, 32'h0, s, e, q);
    check("t2_load4", q, 32'h1234_5678);

    // Misaligned load
    xact(1'b1, 1'b0, 32'h6, 32'h0, s, e, q);
    check("t3_stall", s, 1);
    check("t3_err", {31'b0, e}, 32'h1);
    check("t3_out_held", q, 32'h1234_5678);
    xact(1'b1, 1'b0, 32'h4, 32'h0, s, e, q);
    check("t3_word4", q, 32'h1234_5678);

    // Both ops high, and a store just past the top of the array
    xact(1'b0, 1'b1, 32'h8, 32'h1111_1111, s, e, q);
    xact(1'b1, 1'b1, 32'h8, 32'h2222_2222, s, e, q);
    check("t4_both_err", {31'b0, e}, 32'h1);
    check("t4_both_stall", s, 1);
    xact(1'b0, 1'b1, 32'(WORDS * 4), 32'h3333_3333, s, e, q);
    check("t4_oor_err", {31'b0, e}, 32'h1);
    xact(1'b1, 1'b0, 32'h8, 32'h0, s, e, q);
    check("t4_word8", q, 32'h1111_1111);
    xact(1'b1, 1'b0, 32'h0, 32'h0, s, e, q);
    check("t4_word0", q, 32'hCAFE_0000);

    // Reset in the second wait state of a store
    xact(1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, s, e, q);
    rd = 1'b0; wr = 1'b1; addr = 32'h20; wd = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; wr = 1'b0; addr = '0; wd = '0;
    #1;
    check("t5_out_reset", out, 32'h0);
    check("t5_stall_reset", {31'b0, stall}, 32'h0);
    check("t5_ready_reset", {31'b0, ready}, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    xact(1'b1, 1'b0, 32'h20, 32'h0, s, e, q);
    check("t5_word20", q, 32'h0BAD_F00D);

    // Latency sweep on the LATENCY=1 and LATENCY=4 instances
    aux_xact(1'b0, 1'b1, 32'h40, 32'h5A5A_0F0F, s1, s4, r1, r4, ec);
    check("t6_st_stall_l1", s1, 2);
    check("t6_st_stall_l4", s4, 5);
    check("t6_st_ready_l1", r1, 1);
    check("t6_st_ready_l4", r4, 1);
    aux_xact(1'b1, 1'b0, 32'h40, 32'h0, s1, s4, r1, r4, ec);
    check("t6_ld_stall_l1", s1, 2);
    check("t6_ld_stall_l4", s4, 5);
    check("t6_ld_ready_l1", r1, 1);
    check("t6_ld_ready_l4", r4, 1);
    check("t6_err", ec, 0);
    check("t6_data_l1", out1, 32'h5A5A_0F0F);
    check("t6_data_l4", out4, 32'h5A5A_0F0F);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
